// File: rtl/mem_wb_align_pkg.sv
// Shared constants and types for the MEM/WB register and load alignment.
package mem_wb_align_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LWL_OP = 8'b1110_0010;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_LWR_OP = 8'b1110_0110;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // Stall vector positions of the stages this register sits between
    localparam int StallMem = 4;
    localparam int StallWb  = 5;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic [AluOpBus-1:0]   aluop;
        logic [1:0]            addr_low;
        logic [RegBus-1:0]     rdata;
        logic [RegBus-1:0]     reg2;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
    } mem_wb_t;

    // Contents of an empty slot: reset, flush and bubble all load this
    function automatic mem_wb_t mem_wb_clear();
        mem_wb_t c;
        c.wd       = '0;
        c.wreg     = 1'b0;
        c.wdata    = ZeroWord;
        c.aluop    = EXE_NOP_OP;
        c.addr_low = 2'b00;
        c.rdata    = ZeroWord;
        c.reg2     = ZeroWord;
        c.whilo    = 1'b0;
        c.hi       = ZeroWord;
        c.lo       = ZeroWord;
        return c;
    endfunction

endpackage

// File: rtl/mem_wb_align_load_align.sv
// Combinational big-endian load data alignment (byte offset 0 = bits [31:24]).
module load_align
    import mem_wb_align_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          addr_low,
    input  logic [RegBus-1:0]   rdata,
    input  logic [RegBus-1:0]   reg2,
    input  logic [RegBus-1:0]   wdata,
    input  logic                wreg,
    output logic [RegBus-1:0]   wdata_out,
    output logic                wreg_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the memory word
    always_comb begin
        byte_sel = rdata[31:24];
        unique case (addr_low)
            2'd0: byte_sel = rdata[31:24];
            2'd1: byte_sel = rdata[23:16];
            2'd2: byte_sel = rdata[15:8];
            2'd3: byte_sel = rdata[7:0];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_low[1] ? rdata[15:0] : rdata[31:16];
    end

    // Extend or merge according to the load type; non-loads pass wdata through
    always_comb begin
        wdata_out = wdata;
        wreg_out  = wreg;
        case (aluop)
            EXE_LB_OP:  wdata_out = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: wdata_out = {24'h0, byte_sel};
            EXE_LH_OP, EXE_LHU_OP: begin
                if (addr_low[0]) begin
                    // Misaligned halfword: the fault is taken upstream, so no write here
                    wdata_out = ZeroWord;
                    wreg_out  = 1'b0;
                end else if (aluop == EXE_LH_OP) begin
                    wdata_out = {{16{half_sel[15]}}, half_sel};
                end else begin
                    wdata_out = {16'h0, half_sel};
                end
            end
            EXE_LW_OP:  wdata_out = rdata;
            EXE_LWL_OP: begin
                unique case (addr_low)
                    2'd0: wdata_out = rdata;
                    2'd1: wdata_out = {rdata[23:0], reg2[7:0]};
                    2'd2: wdata_out = {rdata[15:0], reg2[15:0]};
                    2'd3: wdata_out = {rdata[7:0], reg2[23:0]};
                    default: wdata_out = rdata;
                endcase
            end
            EXE_LWR_OP: begin
                unique case (addr_low)
                    2'd0: wdata_out = {reg2[31:8], rdata[31:24]};
                    2'd1: wdata_out = {reg2[31:16], rdata[31:16]};
                    2'd2: wdata_out = {reg2[31:24], rdata[31:8]};
                    2'd3: wdata_out = rdata;
                    default: wdata_out = rdata;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_align.sv
// MEM/WB pipeline register feeding the regfile write port and HI/LO, with load alignment.
module mem_wb_align
    import mem_wb_align_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [AluOpBus-1:0]   mem_aluop,
    input  logic [1:0]            mem_addr_low,
    input  logic [RegBus-1:0]     mem_rdata,
    input  logic [RegBus-1:0]     mem_reg2,
    input  logic                  mem_whilo,
    input  logic [RegBus-1:0]     mem_hi,
    input  logic [RegBus-1:0]     mem_lo,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  wb_whilo,
    output logic [RegBus-1:0]     wb_hi,
    output logic [RegBus-1:0]     wb_lo
);

    mem_wb_t r_q, r_d, mem_in;

    assign mem_in = '{wd:       mem_wd,
                      wreg:     mem_wreg,
                      wdata:    mem_wdata,
                      aluop:    mem_aluop,
                      addr_low: mem_addr_low,
                      rdata:    mem_rdata,
                      reg2:     mem_reg2,
                      whilo:    mem_whilo,
                      hi:       mem_hi,
                      lo:       mem_lo};

    // Next state: flush, then bubble (MEM stalled, WB running), then capture, else hold
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d = mem_wb_clear();
        end else if (stall[StallMem] == Stop && stall[StallWb] == NoStop) begin
            r_d = mem_wb_clear();
        end else if (stall[StallMem] == NoStop) begin
            r_d = mem_in;
        end
    end

    // Register update with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= mem_wb_clear();
        end else begin
            r_q <= r_d;
        end
    end

    load_align u_load_align (
        .aluop     (r_q.aluop),
        .addr_low  (r_q.addr_low),
        .rdata     (r_q.rdata),
        .reg2      (r_q.reg2),
        .wdata     (r_q.wdata),
        .wreg      (r_q.wreg),
        .wdata_out (wb_wdata),
        .wreg_out  (wb_wreg)
    );

    assign wb_wd    = r_q.wd;
    assign wb_whilo = r_q.whilo;
    assign wb_hi    = r_q.hi;
    assign wb_lo    = r_q.lo;

endmodule

// File: tb/tb_mem_wb_align.sv
// Randomised bench for mem_wb_align with a behavioural model and a small regfile.
module tb_mem_wb_align;
    import mem_wb_align_pkg::*;

    localparam logic [7:0] ADD_OP = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_rdata, mem_reg2, mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [1:0]  mem_addr_low;
    logic [4:0]  wb_wd;
    logic        wb_wreg, wb_whilo;
    logic [31:0] wb_wdata, wb_hi, wb_lo;

    always #5 clk = ~clk;

    mem_wb_align dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_addr_low (mem_addr_low),
        .mem_rdata    (mem_rdata),
        .mem_reg2     (mem_reg2),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .wb_whilo     (wb_whilo),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo)
    );

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    logic [4:0]  m_wd;
    logic        m_wreg, m_whilo;
    logic [31:0] m_wdata, m_rdata, m_reg2, m_hi, m_lo;
    logic [7:0]  m_op;
    int unsigned m_off;

    function automatic logic [31:0] align(input logic [7:0] op, input int unsigned off,
                                          input logic [31:0] rd, input logic [31:0] r2,
                                          input logic [31:0] wd);
        longint unsigned r = rd, g = r2, b, h, n;
        b = (r >> (8 * (3 - off))) & 64'hFF;
        h = (r >> (16 * (1 - off / 2))) & 64'hFFFF;
        n = 8 * (off + 1);
        case (op)
            EXE_LB_OP:  return (b >= 128) ? 32'(b | 64'hFFFFFF00) : 32'(b);
            EXE_LBU_OP: return 32'(b);
            EXE_LH_OP:  return (off % 2 == 1) ? 32'h0 : (h >= 32768) ? 32'(h | 64'hFFFF0000)
                                                                      : 32'(h);
            EXE_LHU_OP: return (off % 2 == 1) ? 32'h0 : 32'(h);
            EXE_LW_OP:  return rd;
            EXE_LWL_OP: return 32'((r << (8 * off)) | (g & ((64'd1 << (8 * off)) - 1)));
            EXE_LWR_OP: return 32'((g & ~((64'd1 << n) - 1)) | (r >> (32 - n)));
            default:    return wd;
        endcase
    endfunction

    function automatic logic exp_wreg();
        if ((m_op == EXE_LH_OP || m_op == EXE_LHU_OP) && (m_off % 2 == 1)) return 1'b0;
        return m_wreg;
    endfunction

    // Model of the register contents on each rising edge
    always @(posedge clk) begin
        if (rst || flush || (stall[4] && !stall[5])) begin
            m_wd = 0; m_wreg = 0; m_wdata = 0; m_op = EXE_NOP_OP; m_off = 0;
            m_rdata = 0; m_reg2 = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
            if (rst) m_valid = 1'b1;
        end else if (!stall[4]) begin
            m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata; m_op = mem_aluop;
            m_off = mem_addr_low; m_rdata = mem_rdata; m_reg2 = mem_reg2;
            m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo;
        end
    end

    // Regfile fed by the DUT write port; read bypasses the current write
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (wb_wreg && wb_wd != 5'd0) begin
            rf[wb_wd] <= wb_wdata;
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return rf[a];
    endfunction

    // ---------------- checking ----------------
    int checks = 0, passes = 0;
    bit          lit_en = 0, lit_rf_en = 0;
    logic [31:0] lit_wdata, lit_rf_val;
    logic        lit_wreg, lit_whilo;
    logic [4:0]  lit_rf_addr;
    string       lit_name = "";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Single compare process: model every cycle, plus pinned literal expectations
    always @(negedge clk) begin
        if (m_valid) begin
            check("wb_wd",    32'(wb_wd),    32'(m_wd));
            check("wb_wreg",  32'(wb_wreg),  32'(exp_wreg()));
            check("wb_wdata", wb_wdata,      align(m_op, m_off, m_rdata, m_reg2, m_wdata));
            check("wb_whilo", 32'(wb_whilo), 32'(m_whilo));
            check("wb_hi",    wb_hi,         m_hi);
            check("wb_lo",    wb_lo,         m_lo);
        end
        if (lit_en) begin
            check({lit_name, ".wdata"}, wb_wdata,      lit_wdata);
            check({lit_name, ".wreg"},  32'(wb_wreg),  32'(lit_wreg));
            check({lit_name, ".whilo"}, 32'(wb_whilo), 32'(lit_whilo));
        end
        if (lit_rf_en) check({lit_name, ".rf"}, rf_read(lit_rf_addr), lit_rf_val);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] op, input logic [1:0] off, input logic [31:0] rd,
                         input logic [31:0] r2, input logic [31:0] wd, input logic [4:0] dst,
                         input logic we, input logic hl);
        rst = 0; flush = 0; stall = 6'b0;
        mem_aluop = op; mem_addr_low = off; mem_rdata = rd; mem_reg2 = r2;
        mem_wdata = wd; mem_wd = dst; mem_wreg = we; mem_whilo = hl;
        mem_hi = $urandom; mem_lo = $urandom;
    endtask

    task automatic randomize_inputs();
        mem_wd = 5'($urandom); mem_wreg = 1'($urandom); mem_wdata = $urandom;
        mem_aluop = 8'($urandom); mem_addr_low = 2'($urandom); mem_rdata = $urandom;
        mem_reg2 = $urandom; mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expect the given outputs in the cycle following the last edge
    task automatic expect_out(input string name, input logic [31:0] w, input logic we,
                              input logic hl);
        lit_name = name; lit_wdata = w; lit_wreg = we; lit_whilo = hl; lit_en = 1;
        @(negedge clk); #1;
        lit_en = 0;
    endtask

    task automatic expect_rf(input string name, input logic [4:0] a, input logic [31:0] v);
        lit_name = name; lit_rf_addr = a; lit_rf_val = v; lit_rf_en = 1;
        @(negedge clk); #1;
        lit_rf_en = 0;
    endtask

    localparam logic [31:0] LbExp  [4] = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h7F, 32'h01};
    localparam logic [31:0] LbuExp [4] = '{32'h80, 32'hFF, 32'h7F, 32'h01};

    logic [7:0] op_pool [9];

    initial begin
        op_pool = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                    EXE_LWL_OP, EXE_LWR_OP, EXE_NOP_OP, ADD_OP};
        // Reset with random inputs
        rst = 1; flush = 0; stall = 6'($urandom);
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        expect_out("reset", 32'h0, 1'b0, 1'b0);
        rst = 0;

        for (int i = 0; i < 4; i++) begin
            drive(EXE_LB_OP, 2'(i), 32'h80FF7F01, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
            tick(); expect_out($sformatf("lb%0d", i), LbExp[i], 1'b1, 1'b0);
            drive(EXE_LBU_OP, 2'(i), 32'h80FF7F01, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
            tick(); expect_out($sformatf("lbu%0d", i), LbuExp[i], 1'b1, 1'b0);
        end

        drive(EXE_LWL_OP, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h0, 5'd4, 1'b1, 1'b0);
        tick(); expect_out("lwl1", 32'h223344DD, 1'b1, 1'b0);
        drive(EXE_LWR_OP, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h0, 5'd4, 1'b1, 1'b0);
        tick(); expect_out("lwr2", 32'hAA112233, 1'b1, 1'b0);
        drive(EXE_LWR_OP, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h0, 5'd4, 1'b1, 1'b0);
        tick(); expect_out("lwr3", 32'h11223344, 1'b1, 1'b0);

        drive(EXE_LH_OP, 2'd1, 32'h1234F00D, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
        tick(); expect_out("lh_odd", 32'h0, 1'b0, 1'b0);
        drive(EXE_LH_OP, 2'd2, 32'h1234F00D, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
        tick(); expect_out("lh2", 32'hFFFFF00D, 1'b1, 1'b0);

        // Stall, bubble, flush
        drive(ADD_OP, 2'd0, 32'h0, 32'h0, 32'd7, 5'd5, 1'b1, 1'b1);
        tick(); expect_out("add", 32'd7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(); stall = 6'b110000;
            tick(); expect_out($sformatf("hold%0d", i), 32'd7, 1'b1, 1'b1);
        end
        randomize_inputs(); stall = 6'b010000;
        tick(); expect_out("bubble", 32'h0, 1'b0, 1'b0);
        drive(ADD_OP, 2'd0, 32'h0, 32'h0, 32'd9, 5'd5, 1'b1, 1'b1);
        tick();
        drive(ADD_OP, 2'd0, 32'h0, 32'h0, 32'd11, 5'd5, 1'b1, 1'b1);
        flush = 1;
        tick(); expect_out("flush", 32'h0, 1'b0, 1'b0);

        // Regfile integration: back-to-back LW to r3, then r0 write
        drive(EXE_LW_OP, 2'd0, 32'hCAFEBABE, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(EXE_LW_OP, 2'd2, 32'h0BADF00D, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
        tick(); expect_rf("bypass_r3", 5'd3, 32'h0BADF00D);
        drive(ADD_OP, 2'd0, 32'h0, 32'h0, 32'h55, 5'd0, 1'b1, 1'b0);
        tick(); expect_rf("r0_now", 5'd0, 32'h0);
        drive(EXE_NOP_OP, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick(); expect_rf("r0_after", 5'd0, 32'h0);
        expect_rf("r3_stored", 5'd3, 32'h0BADF00D);

        // Randomised traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 3) != 0) mem_aluop = op_pool[$urandom_range(0, 8)];
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 5))
                0: stall = 6'b110000;
                1: stall = 6'b010000;
                2: stall = 6'b111111;
                3: stall = 6'($urandom);
                default: stall = 6'b000000;
            endcase
            tick();
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_align.md
# mem_wb_align

MEM/WB pipeline register with write-back load-data alignment for the five-stage MIPS32 core. Captures MEM-stage results on each unstalled cycle, then sign/zero-extends and byte-merges load data (LB/LBU/LH/LHU/LW/LWL/LWR, big-endian) into the final write-back value. Its `wb_*` outputs drive the register file write port (`we`/`waddr`/`wdata`) and the HI/LO register. It honours the pipeline controller's stall vector and flush.

## Interface
Parameters: none. Widths come from `defines.v`: `RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8.

- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high (`RstEnable`=1'b1)
- stall  in  6  controller stall vector; bit 4 = MEM, bit 5 = WB
- flush  in  1  exception flush; clears the register
- mem_wd  in  5  destination register address
- mem_wreg  in  1  register write enable
- mem_wdata  in  32  non-load result
- mem_aluop  in  8  op code; selects the load type
- mem_addr_low  in  2  data address bits [1:0]
- mem_rdata  in  32  raw word returned by data memory
- mem_reg2  in  32  old rt value, used for LWL/LWR merge
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  32 each  HI/LO values
- wb_wd  out  5  to regfile `waddr`
- wb_wreg  out  1  to regfile `we`
- wb_wdata  out  32  to regfile `wdata` (aligned)
- wb_whilo  out  1  HI/LO write enable
- wb_hi, wb_lo  out  32 each  HI/LO values

## Operation
- Registered fields: wd, wreg, wdata, aluop, addr_low, rdata, reg2, whilo, hi, lo.
- Per-edge priority, highest first:
  - rst: all fields cleared to 0; aluop = `EXE_NOP_OP`.
  - flush: same clear as rst.
  - stall[4]=Stop and stall[5]=NoStop: insert a bubble (same clear).
  - stall[4]=NoStop: capture the `mem_*` inputs.
  - otherwise: hold all fields.
- wb_wdata is a combinational function of the registered fields. Byte offset 0 = bits [31:24].
- LB / LBU: selected byte, sign- / zero-extended.
- LH / LHU: offset 0 → [31:16], offset 2 → [15:0], sign- / zero-extended.
  - Odd offset: wb_wdata=0 and wb_wreg forced 0. The exception is raised upstream; no write occurs here.
- LW: full rdata, any offset. Alignment faults are handled upstream.
- LWL by offset:
  - 0 → rdata
  - 1 → {rdata[23:0], reg2[7:0]}
  - 2 → {rdata[15:0], reg2[15:0]}
  - 3 → {rdata[7:0], reg2[23:0]}
- LWR by offset:
  - 0 → {reg2[31:8], rdata[31:24]}
  - 1 → {reg2[31:16], rdata[31:16]}
  - 2 → {reg2[31:24], rdata[31:8]}
  - 3 → rdata
- All other aluop values: wb_wdata = registered wdata.
- wb_wd, wb_whilo, wb_hi, wb_lo pass straight from the register. wb_wreg passes through except for the odd-halfword override.
- Register 0 writes are suppressed by the regfile, not here.

## Timing
- Latency: one cycle from MEM inputs to `wb_*`.
- Outputs are valid combinationally after the edge, within the same cycle that the regfile samples and bypasses them.
- Reset values of all outputs: 0.
- Stall combinations:
  - Bubble (stall[4]=1, stall[5]=0): the next cycle shows wb_wreg=0 and wb_whilo=0.
  - Full WB stall (stall[5]=1): holds for any number of cycles. Outputs are stable, so a regfile write repeats the same value (idempotent).
- Simultaneous flush + stall: flush wins.
- rst during a stall: clear wins.
- No handshake beyond the stall vector; the block never back-pressures.

## Structure
- All op codes (`EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_LWL_OP`, `EXE_LWR_OP`, `EXE_NOP_OP`), `Stop`/`NoStop`, `ZeroWord`, and the bus widths live in shared `defines.v`. No local literals.
- One sub-module: `load_align`. It is purely combinational: (aluop, addr_low, rdata, reg2, wdata, wreg) → (wdata_out, wreg_out).
- Top level holds the register and the stall/flush priority.

## Test plan
- Reset then idle: assert rst for 2 cycles with random inputs → all `wb_*` = 0. Release → values captured on the next edge.
- LB/LBU: rdata=0x80FF7F01, offsets 0–3:
  - LB → 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001
  - LBU → 0x00000080, 0x000000FF, 0x0000007F, 0x00000001
- LWL/LWR: rdata=0x11223344, reg2=0xAABBCCDD:
  - LWL offset 1 → 0x223344DD
  - LWR offset 2 → 0xAA112233
  - LWR offset 3 → 0x11223344
- LH odd offset: LH at offset 1 with wreg=1 → wb_wreg=0, wb_wdata=0. Same op at offset 2 with rdata=0x1234F00D → 0xFFFFF00D, wb_wreg=1.
- Stall/bubble: capture ADD (wd=5, wdata=7).
  - stall=6'b110000 for 3 cycles → outputs held.
  - Then stall=6'b010000 → next cycle wb_wreg=0 and wb_whilo=0.
  - Flush asserted together with stall[4]=NoStop → cleared, not captured.
- Regfile integration: drive wb_* into regfile. Back-to-back LW to r3, then read r3 in the same cycle → read returns the aligned value via bypass. Write to r0 → r0 reads 0.
